// File: rtl/spi_slave_core.sv
// SPI slave on the system clock: synchronises ss/sclk/mosi, shifts one character per segment,
// and exchanges parallel words through a tx holding register and an rx valid pulse.
module spi_slave_core #(
  parameter int unsigned MAX_CHAR    = 32,
  parameter int unsigned CLW         = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst_in,
  input  logic                ss_n_in,
  input  logic                sclk_in,
  input  logic                mosi_in,
  output logic                miso_out,
  output logic                miso_oe_out,
  input  logic [CLW-1:0]      cfg_char_len,
  input  logic                cfg_tx_neg,
  input  logic                cfg_rx_neg,
  input  logic                cfg_lsb,
  input  logic [MAX_CHAR-1:0] tx_data_in,
  input  logic                tx_valid_in,
  output logic                tx_ready_out,
  output logic [MAX_CHAR-1:0] rx_data_out,
  output logic                rx_valid_out,
  output logic                tx_underrun_out,
  output logic                abort_out,
  output logic                busy_out
);

  localparam int unsigned NW = CLW + 1;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES:0]   r_sync_vld;
  logic                   r_ss_d;
  logic                   r_sclk_d;

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      r_ss_sync   <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sync_vld  <= '0;
      r_ss_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_in};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
      r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
    end
  end

  logic w_ss;
  logic w_sclk;
  logic w_mosi;
  logic w_sync_valid;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_sclk_rise;
  logic w_sclk_fall;

  assign w_ss         = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
  // The reset value of the ss chain must not count as "seen high"; wait until real data has
  // flushed through both the synchroniser and the edge-detect flop.
  assign w_sync_valid = r_sync_vld[SYNC_STAGES];
  assign w_ss_fall    = r_ss_d & ~w_ss;
  assign w_ss_rise    = ~r_ss_d & w_ss;
  assign w_sclk_rise  = w_sclk & ~r_sclk_d;
  assign w_sclk_fall  = ~w_sclk & r_sclk_d;

  // Character state
  state_e                r_state;
  logic                  r_armed;
  logic [MAX_CHAR-1:0]   r_hold;
  logic                  r_tx_ready;
  logic [MAX_CHAR-1:0]   r_tx_word;
  logic [MAX_CHAR-1:0]   r_rx_shift;
  logic [MAX_CHAR-1:0]   r_rx_data;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic                  r_abort;
  logic                  r_miso;
  logic                  r_busy;
  logic [NW-1:0]         r_cnt;
  logic [NW-1:0]         r_len;
  logic                  r_lsb;
  logic                  r_tx_neg;
  logic                  r_rx_neg;

  function automatic logic [CLW-1:0] f_idx(input logic [NW-1:0] n, input logic [NW-1:0] len,
                                           input logic lsb);
    logic [NW-1:0] t;
    t = lsb ? n : (len - n - NW'(1));
    return t[CLW-1:0];
  endfunction

  logic                w_accept;
  logic                w_have_word;
  logic [MAX_CHAR-1:0] w_load_word;
  logic [MAX_CHAR-1:0] w_word_start;
  logic [NW-1:0]       w_start_len;
  logic                w_char_done;
  logic                w_do_start;
  logic                w_sample;
  logic                w_update;
  logic [NW-1:0]       w_cnt_new;
  logic [CLW-1:0]      w_idx_cur;
  logic [CLW-1:0]      w_idx_new;
  logic [CLW-1:0]      w_idx_start;

  assign w_accept     = tx_valid_in & r_tx_ready;
  assign w_have_word  = w_accept | ~r_tx_ready;
  assign w_load_word  = w_accept ? tx_data_in : r_hold;
  assign w_word_start = w_have_word ? w_load_word : '0;
  assign w_start_len  = (cfg_char_len == '0) ? NW'(MAX_CHAR) : {1'b0, cfg_char_len};
  assign w_char_done  = (r_state == StActive) && (r_cnt == r_len);
  assign w_do_start   = ((r_state == StIdle) && w_ss_fall && r_armed) ||
                        (w_char_done && !w_ss_rise);
  assign w_sample     = (r_state == StActive) && !w_char_done &&
                        (r_tx_neg ? w_sclk_rise : w_sclk_fall);
  assign w_update     = (r_state == StActive) && !w_char_done &&
                        (r_rx_neg ? w_sclk_fall : w_sclk_rise);
  assign w_cnt_new    = r_cnt + {{(NW-1){1'b0}}, w_sample};
  assign w_idx_cur    = f_idx(r_cnt, r_len, r_lsb);
  assign w_idx_new    = f_idx(w_cnt_new, r_len, r_lsb);
  assign w_idx_start  = f_idx(NW'(0), w_start_len, cfg_lsb);

  always_ff @(posedge wb_clk_in or negedge wb_rst_in) begin
    if (!wb_rst_in) begin
      r_state    <= StIdle;
      r_armed    <= 1'b0;
      r_hold     <= '0;
      r_tx_ready <= 1'b1;
      r_tx_word  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      r_miso     <= 1'b0;
      r_busy     <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_lsb      <= 1'b0;
      r_tx_neg   <= 1'b0;
      r_rx_neg   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      r_abort    <= 1'b0;
      if (w_sync_valid && w_ss) r_armed <= 1'b1;
      if (w_accept) begin
        r_hold     <= tx_data_in;
        r_tx_ready <= 1'b0;
      end
      case (r_state)
        StIdle: begin
          if (w_ss_fall && r_armed) begin
            r_state <= StActive;
            r_busy  <= 1'b1;
          end
        end
        StActive: begin
          if (w_char_done) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            if (w_ss_rise) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_miso  <= 1'b0;
            end
          end else if (w_ss_rise) begin
            // Partial character: rx bits are dropped and the loaded tx word is gone.
            r_abort <= (r_cnt != '0);
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_miso  <= 1'b0;
          end else begin
            if (w_sample) r_rx_shift[w_idx_cur] <= w_mosi;
            r_cnt <= w_cnt_new;
            if (w_update && (w_cnt_new != r_len)) r_miso <= r_tx_word[w_idx_new];
          end
        end
        default: r_state <= StIdle;
      endcase
      if (w_do_start) begin
        r_len      <= w_start_len;
        r_lsb      <= cfg_lsb;
        r_tx_neg   <= cfg_tx_neg;
        r_rx_neg   <= cfg_rx_neg;
        r_cnt      <= '0;
        r_rx_shift <= '0;
        r_tx_word  <= w_word_start;
        r_miso     <= w_word_start[w_idx_start];
        r_underrun <= ~w_have_word;
        r_tx_ready <= 1'b1;
      end
    end
  end

  assign miso_out        = r_miso;
  assign miso_oe_out     = r_busy;
  assign busy_out        = r_busy;
  assign tx_ready_out    = r_tx_ready;
  assign rx_data_out     = r_rx_data;
  assign rx_valid_out    = r_rx_valid;
  assign tx_underrun_out = r_underrun;
  assign abort_out       = r_abort;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a behavioural SPI master drives table vectors, then
// abort and mid-frame reset sequences.
module tb_spi_slave_core;

  logic        wb_clk_in = 1'b0;
  logic        wb_rst_in = 1'b0;
  logic        ss_n_in = 1'b1;
  logic        sclk_in = 1'b0;
  logic        mosi_in = 1'b0;
  logic        miso_out;
  logic        miso_oe_out;
  logic [4:0]  cfg_char_len = 5'd4;
  logic        cfg_tx_neg = 1'b1;
  logic        cfg_rx_neg = 1'b0;
  logic        cfg_lsb = 1'b1;
  logic [31:0] tx_data_in = '0;
  logic        tx_valid_in = 1'b0;
  logic        tx_ready_out;
  logic [31:0] rx_data_out;
  logic        rx_valid_out;
  logic        tx_underrun_out;
  logic        abort_out;
  logic        busy_out;

  spi_slave_core #(.MAX_CHAR(32), .CLW(5), .SYNC_STAGES(2)) dut (
    .wb_clk_in       (wb_clk_in),
    .wb_rst_in       (wb_rst_in),
    .ss_n_in         (ss_n_in),
    .sclk_in         (sclk_in),
    .mosi_in         (mosi_in),
    .miso_out        (miso_out),
    .miso_oe_out     (miso_oe_out),
    .cfg_char_len    (cfg_char_len),
    .cfg_tx_neg      (cfg_tx_neg),
    .cfg_rx_neg      (cfg_rx_neg),
    .cfg_lsb         (cfg_lsb),
    .tx_data_in      (tx_data_in),
    .tx_valid_in     (tx_valid_in),
    .tx_ready_out    (tx_ready_out),
    .rx_data_out     (rx_data_out),
    .rx_valid_out    (rx_valid_out),
    .tx_underrun_out (tx_underrun_out),
    .abort_out       (abort_out),
    .busy_out        (busy_out)
  );

  always #5 wb_clk_in = ~wb_clk_in;

  int n_checks = 0;
  int n_err = 0;

  int          rxv_cnt = 0;
  int          und_cnt = 0;
  int          abort_cnt = 0;
  logic [31:0] last_rx = '0;

  always @(negedge wb_clk_in) begin
    if (rx_valid_out) begin
      rxv_cnt = rxv_cnt + 1;
      last_rx = rx_data_out;
    end
    if (tx_underrun_out) und_cnt = und_cnt + 1;
    if (abort_out) abort_cnt = abort_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural master state
  int          m_len;
  int          m_bit;
  logic        m_lsb;
  logic        m_tx_neg;
  logic        m_rx_neg;
  logic [31:0] m_tx;
  logic [31:0] m_rx;

  task automatic half();
    repeat (8) @(posedge wb_clk_in);
    #2;
  endtask

  task automatic set_cfg(input logic [4:0] len, input logic txn, input logic rxn,
                         input logic lsb);
    cfg_char_len = len;
    cfg_tx_neg   = txn;
    cfg_rx_neg   = rxn;
    cfg_lsb      = lsb;
    m_len        = (len == 5'd0) ? 32 : int'(len);
    m_tx_neg     = txn;
    m_rx_neg     = rxn;
    m_lsb        = lsb;
  endtask

  task automatic spi_bit();
    int idx;
    idx = m_lsb ? m_bit : m_len - 1 - m_bit;
    if (m_tx_neg) mosi_in = m_tx[idx];
    half();
    sclk_in = 1'b1;
    if (!m_tx_neg) mosi_in = m_tx[idx];
    if (!m_rx_neg) m_rx[idx] = miso_out;
    half();
    sclk_in = 1'b0;
    if (m_rx_neg) m_rx[idx] = miso_out;
    m_bit++;
  endtask

  task automatic frame_open(input logic [31:0] tx);
    m_tx    = tx;
    m_rx    = '0;
    m_bit   = 0;
    ss_n_in = 1'b0;
    half();
  endtask

  task automatic frame_bits(input int n);
    for (int k = 0; k < n; k++) spi_bit();
  endtask

  task automatic frame_close();
    half();
    ss_n_in = 1'b1;
    repeat (10) @(posedge wb_clk_in);
    #2;
  endtask

  task automatic push_tx(input logic [31:0] w);
    @(negedge wb_clk_in);
    tx_data_in  = w;
    tx_valid_in = 1'b1;
    @(negedge wb_clk_in);
    tx_valid_in = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [4:0]  len;
    logic        tx_neg;
    logic        rx_neg;
    logic        lsb;
    logic [31:0] mosi;
    logic        preload;
    logic [31:0] stx;
    logic [31:0] exp_rx;
    logic [31:0] exp_mrx;
    int          exp_und;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b_rxv;
    int b_und;
    int b_abt;

    vecs[0] = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h0000_236F, 1'b0, 32'h0, 32'h0000_000F, 32'h0, 2};
    vecs[1] = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h0000_0006, 1'b1, 32'hA, 32'h0000_0006, 32'hA, 1};
    vecs[2] = '{5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_00A5, 1'b1, 32'h3C, 32'h0000_00A5, 32'h3C, 1};
    vecs[3] = '{5'd4, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0, 32'h0, 32'h0, 2};
    vecs[4] = '{5'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF,
                32'h1234_5678, 1};
    vecs[5] = '{5'd8, 1'b0, 1'b1, 1'b0, 32'h0000_FFFF, 1'b1, 32'h81, 32'h0000_00FF, 32'h81, 1};
    vecs[6] = '{5'd3, 1'b1, 1'b0, 1'b0, 32'h0000_0005, 1'b1, 32'h3, 32'h0000_0005, 32'h3, 1};
    vecs[7] = '{5'd1, 1'b0, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 32'h1, 32'h0000_0001, 32'h1, 1};

    set_cfg(5'd4, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge wb_clk_in);
    #2;
    check("rst_busy", {31'b0, busy_out}, 32'd0);
    check("rst_tx_ready", {31'b0, tx_ready_out}, 32'd1);
    wb_rst_in = 1'b1;
    repeat (6) @(posedge wb_clk_in);
    #2;
    check("rst_miso", {31'b0, miso_out}, 32'd0);
    check("rst_miso_oe", {31'b0, miso_oe_out}, 32'd0);
    check("rst_tx_ready_after", {31'b0, tx_ready_out}, 32'd1);
    check("rst_rx_data", rx_data_out, 32'd0);
    check("rst_pulses", {29'b0, rx_valid_out, tx_underrun_out, abort_out}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      set_cfg(vecs[i].len, vecs[i].tx_neg, vecs[i].rx_neg, vecs[i].lsb);
      if (vecs[i].preload) begin
        check($sformatf("v%0d_ready_before", i), {31'b0, tx_ready_out}, 32'd1);
        push_tx(vecs[i].stx);
        check($sformatf("v%0d_ready_held", i), {31'b0, tx_ready_out}, 32'd0);
      end
      b_rxv = rxv_cnt;
      b_und = und_cnt;
      b_abt = abort_cnt;
      frame_open(vecs[i].mosi);
      check($sformatf("v%0d_busy_oe", i), {30'b0, busy_out, miso_oe_out}, 32'd3);
      frame_bits(m_len);
      frame_close();
      check($sformatf("v%0d_rx_data", i), last_rx, vecs[i].exp_rx);
      check($sformatf("v%0d_rx_valid_cnt", i), rxv_cnt - b_rxv, 32'd1);
      check($sformatf("v%0d_master_rx", i), m_rx, vecs[i].exp_mrx);
      check($sformatf("v%0d_underrun_cnt", i), und_cnt - b_und, vecs[i].exp_und);
      check($sformatf("v%0d_abort_cnt", i), abort_cnt - b_abt, 32'd0);
      check($sformatf("v%0d_ready_after", i), {31'b0, tx_ready_out}, 32'd1);
      check($sformatf("v%0d_idle", i), {30'b0, busy_out, miso_out}, 32'd0);
    end

    // ss rises after 2 of 4 bits
    set_cfg(5'd4, 1'b1, 1'b0, 1'b1);
    b_rxv = rxv_cnt;
    b_abt = abort_cnt;
    frame_open(32'hF);
    frame_bits(2);
    frame_close();
    check("abort_cnt", abort_cnt - b_abt, 32'd1);
    check("abort_no_rx_valid", rxv_cnt - b_rxv, 32'd0);
    check("abort_idle", {30'b0, busy_out, miso_oe_out}, 32'd0);
    b_rxv = rxv_cnt;
    b_abt = abort_cnt;
    frame_open(32'h5);
    frame_bits(4);
    frame_close();
    check("after_abort_rx", last_rx, 32'h5);
    check("after_abort_rx_cnt", rxv_cnt - b_rxv, 32'd1);
    check("after_abort_no_abort", abort_cnt - b_abt, 32'd0);

    // Reset mid-frame, released while ss is still low
    b_rxv = rxv_cnt;
    b_abt = abort_cnt;
    frame_open(32'h6);
    frame_bits(2);
    check("midrst_busy_before", {31'b0, busy_out}, 32'd1);
    wb_rst_in = 1'b0;
    repeat (3) @(posedge wb_clk_in);
    #2;
    check("midrst_busy_in_reset", {31'b0, busy_out}, 32'd0);
    wb_rst_in = 1'b1;
    frame_bits(2);
    check("midrst_no_reentry", {31'b0, busy_out}, 32'd0);
    frame_close();
    check("midrst_no_rx_valid", rxv_cnt - b_rxv, 32'd0);
    check("midrst_no_abort", abort_cnt - b_abt, 32'd0);
    b_rxv = rxv_cnt;
    frame_open(32'h9);
    frame_bits(4);
    frame_close();
    check("midrst_next_rx", last_rx, 32'h9);
    check("midrst_next_rx_cnt", rxv_cnt - b_rxv, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
